next_pc_unit: RTL and testbench

- Generates `pc_in` and `enable` for program_counter; the other direction of the PC interface.
- Consumes `pc_out` and `pc_added`, plus decoded control-flow requests from the decoder, and selects the next PC from: sequential, relative branch, absolute jump, call, return or halt.
- Holds a small return-address stack and a RUN/HALTED state machine.

---
 rtl/next_pc_unit.sv | 125 ++++++++++++
 tb/tb_next_pc_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: selects the next program counter value (sequential, relative
// branch, absolute jump, call, return, halt) for program_counter, and keeps a
// small return-address stack plus a RUN/HALTED state machine.
//
// Handshake: there is no valid/ready pair here. `stall` is the only
// back-pressure. While it is high, the unit holds the PC (enable=0,
// pc_in=pc_out) and ignores every control request. The PC moves only in a
// cycle where enable=1, and program_counter captures pc_in on that rising edge.
module next_pc_unit #(
    parameter int D = 12,
    parameter int O = 8,
    parameter int S = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [D-1:0]         pc_out,
    input  logic [D-1:0]         pc_added,
    input  logic                 stall,
    input  logic                 branch,
    input  logic [O-1:0]         offset,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 halt,
    input  logic [D-1:0]         target,
    output logic [D-1:0]         pc_in,
    output logic                 enable,
    output logic                 done,
    output logic                 stack_err,
    output logic [$clog2(S):0]   depth,
    output logic                 state_dbg
);

    localparam int AW = $clog2(S);
    localparam int DW = AW + 1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            err_q, err_d;
    logic [D-1:0]    stack_q [S];
    logic [D-1:0]    stack_d [S];

    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   push_idx;
    logic [D-1:0]    branch_tgt;

    // The top entry sits one below the occupancy count. The next free slot is
    // the count itself, which is only used while depth < S.
    assign top_idx    = AW'(depth_q - DW'(1));
    assign push_idx   = depth_q[AW-1:0];
    // Sign-extend the offset to D bits. The sum then wraps mod 2^D in both directions.
    assign branch_tgt = pc_out + {{(D-O){offset[O-1]}}, offset};

    assign depth     = depth_q;
    assign stack_err = err_q;
    assign state_dbg = state_q;

    // Next-PC select and next-state logic, with fixed priority halt > ret > call > jump > branch
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        err_d   = err_q;
        stack_d = stack_q;
        pc_in   = pc_added;
        enable  = 1'b1;
        done    = 1'b0;

        if (state_q == HALTED) begin
            enable = 1'b0;
            done   = 1'b1;
            pc_in  = pc_out;
        end else if (stall) begin
            enable = 1'b0;
            pc_in  = pc_out;
        end else if (halt) begin
            pc_in   = pc_out;
            state_d = HALTED;
        end else if (ret) begin
            if (depth_q != '0) begin
                pc_in   = stack_q[top_idx];
                depth_d = depth_q - DW'(1);
            end else begin
                // Underflow: fall through to sequential and flag the error.
                pc_in = pc_added;
                err_d = 1'b1;
            end
        end else if (call) begin
            pc_in = target;
            if (depth_q < DW'(S)) begin
                stack_d[push_idx] = pc_added;
                depth_d           = depth_q + DW'(1);
            end else begin
                // Overflow: the call still happens, but its return address is lost.
                err_d = 1'b1;
            end
        end else if (jump) begin
            pc_in = target;
        end else if (branch) begin
            pc_in = branch_tgt;
        end else begin
            pc_in = pc_added;
        end
    end

    // State, stack, depth and sticky error register; async reset empties the stack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            depth_q <= '0;
            err_q   <= 1'b0;
            stack_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Testbench for next_pc_unit: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the next-PC rules.
module tb_next_pc_unit;

    localparam int D = 12;
    localparam int O = 8;
    localparam int S = 4;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT ----------------
    logic [D-1:0]         pc_out, pc_added, target, pc_in;
    logic [O-1:0]         offset;
    logic                 stall, branch, jump, call, ret, halt;
    logic                 enable, done, stack_err, state_dbg;
    logic [$clog2(S):0]   depth;

    next_pc_unit #(.D(D), .O(O), .S(S)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc_out    (pc_out),
        .pc_added  (pc_added),
        .stall     (stall),
        .branch    (branch),
        .offset    (offset),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .halt      (halt),
        .target    (target),
        .pc_in     (pc_in),
        .enable    (enable),
        .done      (done),
        .stack_err (stack_err),
        .depth     (depth),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int            n_vec;
    int            n_err;
    logic [D-1:0]  exp_q[$];     // return-address stack, back = top
    bit            m_halted;
    bit            m_err;
    logic [D-1:0]  m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D-1:0] wrap_add(input logic [D-1:0] base, input logic [O-1:0] off);
        int v;
        int m;
        m = 1 << D;
        v = int'(base) + int'($signed(off));
        v = ((v % m) + m) % m;
        return D'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_halted = 1'b0;
        m_err    = 1'b0;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_comb(output logic [D-1:0] e_pc, output logic e_en, output logic e_done);
        e_done = m_halted;
        e_en   = !(m_halted || stall);
        if (m_halted || stall || halt) e_pc = pc_out;
        else if (ret)                  e_pc = (exp_q.size() > 0) ? exp_q[$] : pc_added;
        else if (call || jump)         e_pc = target;
        else if (branch)               e_pc = wrap_add(pc_out, offset);
        else                           e_pc = pc_added;
    endtask

    // Model update at the rising edge.
    task automatic model_seq();
        if (!m_halted && !stall) begin
            if (halt) m_halted = 1'b1;
            else if (ret) begin
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                else m_err = 1'b1;
            end else if (call) begin
                if (exp_q.size() < S) exp_q.push_back(pc_added);
                else m_err = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic setin(input logic [D-1:0] po, input bit st, input bit br, input logic [O-1:0] off,
                         input bit jp, input bit cl, input bit rt, input bit hl, input logic [D-1:0] tg);
        pc_out   = po;
        pc_added = po + D'(1);
        stall    = st;
        branch   = br;
        offset   = off;
        jump     = jp;
        call     = cl;
        ret      = rt;
        halt     = hl;
        target   = tg;
    endtask

    // Check outputs against the model (plus an optional fixed expected pc_in), then clock once.
    task automatic cycle(input bit use_want, input logic [D-1:0] want);
        logic [D-1:0] e_pc;
        logic         e_en, e_done;
        model_comb(e_pc, e_en, e_done);
        #1;
        chk("pc_in", 32'(pc_in), 32'(e_pc));
        chk("enable", 32'(enable), 32'(e_en));
        chk("done", 32'(done), 32'(e_done));
        chk("depth", 32'(depth), 32'(exp_q.size()));
        chk("stack_err", 32'(stack_err), 32'(m_err));
        if (use_want) chk("pc_in_directed", 32'(pc_in), 32'(want));
        @(posedge clock);
        model_seq();
        if (e_en) m_pc = e_pc;
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        setin(m_pc, 0, 0, '0, 0, 0, 0, 0, '0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_stack_err", 32'(stack_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_enable", 32'(enable), 32'd1);
        chk("rst_pc_in", 32'(pc_in), 32'(pc_added));
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        m_pc  = '0;
        reset = 1'b1;
        setin('0, 0, 0, '0, 0, 0, 0, 0, '0);
        #12;
        reset = 1'b0;

        // Reset state, then 10 cycles of sequential fetch with the PC looping.
        for (int i = 0; i < 10; i++) begin
            setin(m_pc, 0, 0, '0, 0, 0, 0, 0, '0);
            cycle(1, D'(i + 1));
        end

        // Relative branches, backwards and wrapping below zero.
        setin(12'h010, 0, 1, 8'hFE, 0, 0, 0, 0, '0);
        cycle(1, 12'h00E);
        setin(12'h001, 0, 1, 8'hFC, 0, 0, 0, 0, '0);
        cycle(1, 12'hFFD);
        setin(12'hFF0, 0, 1, 8'h7F, 0, 0, 0, 0, '0);
        cycle(1, 12'h06F);

        // Single call / return.
        setin(12'h010, 0, 0, '0, 0, 1, 0, 0, 12'h200);
        cycle(1, 12'h200);
        chk("depth_after_call", 32'(depth), 32'd1);
        setin(12'h205, 0, 0, '0, 0, 0, 1, 0, '0);
        cycle(1, 12'h011);
        chk("depth_after_ret", 32'(depth), 32'd0);

        // Five calls overflow a 4-deep stack, then five returns underflow it.
        for (int i = 0; i < 5; i++) begin
            setin(D'(32 * i), 0, 0, '0, 0, 1, 0, 0, D'(256 + i));
            cycle(1, D'(256 + i));
        end
        chk("depth_sat", 32'(depth), 32'd4);
        chk("err_overflow", 32'(stack_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            setin(12'h500, 0, 0, '0, 0, 0, 1, 0, '0);
            cycle(1, (i < 4) ? D'(32 * (3 - i) + 1) : 12'h501);
        end
        chk("err_sticky", 32'(stack_err), 32'd1);

        // call+ret together: ret wins on an empty stack, no push.
        setin(12'h060, 0, 0, '0, 0, 1, 1, 0, 12'h700);
        cycle(1, 12'h061);
        chk("callret_depth", 32'(depth), 32'd0);

        // Stall blocks a jump; releasing it lets the jump through.
        setin(12'h123, 1, 0, '0, 1, 0, 0, 0, 12'h300);
        cycle(1, 12'h123);
        setin(12'h123, 0, 0, '0, 1, 0, 0, 0, 12'h300);
        cycle(1, 12'h300);

        // Push one entry, then halt+call: halt wins, depth unchanged, done next cycle.
        setin(12'h030, 0, 0, '0, 0, 1, 0, 0, 12'h040);
        cycle(1, 12'h040);
        setin(12'h040, 0, 0, '0, 0, 1, 0, 1, 12'h555);
        cycle(1, 12'h040);
        setin(12'h040, 0, 1, 8'h05, 1, 1, 1, 0, 12'h777);
        cycle(1, 12'h040);
        chk("halted_depth", 32'(depth), 32'd1);
        chk("halted_done", 32'(done), 32'd1);
        async_reset();

        // Randomized traffic against the reference model.
        m_pc = '0;
        for (int n = 0; n < 600; n++) begin
            setin(m_pc,
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0),
                  O'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 59) == 0),
                  D'($urandom));
            cycle(0, '0);
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
